// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    localparam int CELLS = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAYER_WAIT,
        S_AUTO_SAMPLE,
        S_CPU_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Eight winning lines as cell masks, bit i = cell i (row-major).
    localparam logic [7:0][CELLS-1:0] WIN_LINES = {
        9'h007,   // 0,1,2
        9'h038,   // 3,4,5
        9'h1C0,   // 6,7,8
        9'h049,   // 0,3,6
        9'h092,   // 1,4,7
        9'h124,   // 2,5,8
        9'h111,   // 0,4,8
        9'h054    // 2,4,6
    };

    // A cell index is playable when it names a real cell that nobody holds.
    function automatic logic cell_free(input logic [CELLS-1:0] occ, input logic [3:0] idx);
        if (idx >= 4'(CELLS)) return 1'b0;
        return !occ[idx];
    endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Player/generator-facing signal bundle of the turn controller.
interface ttt_turn_controller_if;
    import ttt_pkg::*;

    logic             start;
    logic             move_valid;
    logic [3:0]       move_idx;
    logic [3:0]       rand_cell;
    logic [CELLS-1:0] Xcells;
    logic [CELLS-1:0] Ocells;
    logic             cpu_turn;
    logic             move_ack;
    logic             move_err;
    logic             cpu_move_valid;
    logic [3:0]       cpu_move_idx;
    logic             game_over;
    logic [1:0]       winner;

    // Driver side: player, game host and random_generator.
    modport master (
        output start, move_valid, move_idx, rand_cell,
        input  Xcells, Ocells, cpu_turn, move_ack, move_err,
               cpu_move_valid, cpu_move_idx, game_over, winner
    );

    // Controller side.
    modport slave (
        input  start, move_valid, move_idx, rand_cell,
        output Xcells, Ocells, cpu_turn, move_ack, move_err,
               cpu_move_valid, cpu_move_idx, game_over, winner
    );

endinterface

// File: rtl/ttt_board_eval.sv
// Combinational board evaluator: line detection on one player's marks,
// plus full-board and lowest-free-cell on the combined occupancy.
module ttt_board_eval
    import ttt_pkg::*;
(
    input  logic [CELLS-1:0] i_marks,
    input  logic [CELLS-1:0] i_occ,
    output logic             o_has_line,
    output logic             o_full,
    output logic [3:0]       o_first_free
);

    assign o_full = &i_occ;

    // Any winning mask fully covered by the marks is a line.
    always_comb begin
        o_has_line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((i_marks & WIN_LINES[i]) == WIN_LINES[i]) o_has_line = 1'b1;
        end
    end

    // Scan downward so the lowest free index wins; 4'hF when the board is full.
    always_comb begin
        o_first_free = 4'hF;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!i_occ[i]) o_first_free = 4'(i);
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns both boards, accepts player moves,
// picks CPU (and timed-out player) moves from the random generator with a
// deterministic lowest-free fallback, and scores the board after every move.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int MAX_TRIES    = 8,
    parameter int TURN_TIMEOUT = 1024,
    parameter int CPU_FIRST    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ttt_turn_controller_if.slave  bus
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int TO_W  = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    // Mover encoding: 0 = X (player), 1 = O (CPU).
    state_t           r_state, w_state_nxt;
    logic [CELLS-1:0] r_xcells, w_xcells_nxt;
    logic [CELLS-1:0] r_ocells, w_ocells_nxt;
    logic             r_mover, w_mover_nxt;
    logic [TRY_W-1:0] r_try, w_try_nxt;
    logic [TO_W-1:0]  r_to, w_to_nxt;
    winner_t          r_winner, w_winner_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_err, w_err_nxt;
    logic             r_cmv, w_cmv_nxt;
    logic [3:0]       r_cidx, w_cidx_nxt;

    logic [CELLS-1:0] w_occ;
    logic [CELLS-1:0] w_eval_marks;
    logic             w_has_line;
    logic             w_full;
    logic [3:0]       w_first_free;
    logic             w_sample_ok;
    logic             w_player_ok;
    logic             w_to_hit;
    logic [3:0]       w_pick;
    logic [CELLS-1:0] w_pick_mask;
    logic [CELLS-1:0] w_player_mask;

    assign w_occ        = r_xcells | r_ocells;
    // In CHECK the mover's own board is scored; elsewhere only occupancy matters.
    assign w_eval_marks = r_mover ? r_ocells : r_xcells;

    ttt_board_eval u_eval (
        .i_marks      (w_eval_marks),
        .i_occ        (w_occ),
        .o_has_line   (w_has_line),
        .o_full       (w_full),
        .o_first_free (w_first_free)
    );

    assign w_sample_ok   = cell_free(w_occ, bus.rand_cell);
    assign w_player_ok   = cell_free(w_occ, bus.move_idx);
    assign w_to_hit      = (TURN_TIMEOUT != 0) && (r_to == TO_LAST);
    // Selection states are only entered with a free cell, so the fallback is valid.
    assign w_pick        = w_sample_ok ? bus.rand_cell : w_first_free;
    assign w_pick_mask   = CELLS'(1) << w_pick;
    assign w_player_mask = CELLS'(1) << bus.move_idx;

    // Next-state and next-register computation; start overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_xcells_nxt = r_xcells;
        w_ocells_nxt = r_ocells;
        w_mover_nxt  = r_mover;
        w_try_nxt    = r_try;
        w_to_nxt     = r_to;
        w_winner_nxt = r_winner;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_cmv_nxt    = 1'b0;
        w_cidx_nxt   = r_cidx;

        if (bus.start) begin
            w_state_nxt  = (CPU_FIRST != 0) ? S_CPU_SAMPLE : S_PLAYER_WAIT;
            w_xcells_nxt = '0;
            w_ocells_nxt = '0;
            w_mover_nxt  = (CPU_FIRST != 0);
            w_try_nxt    = '0;
            w_to_nxt     = '0;
            w_winner_nxt = WIN_NONE;
        end else begin
            case (r_state)
                S_PLAYER_WAIT: begin
                    if (bus.move_valid && w_player_ok) begin
                        w_xcells_nxt = r_xcells | w_player_mask;
                        w_mover_nxt  = 1'b0;
                        w_ack_nxt    = 1'b1;
                        w_state_nxt  = S_CHECK;
                    end else begin
                        w_err_nxt = bus.move_valid;
                        if (w_to_hit) begin
                            w_try_nxt   = '0;
                            w_state_nxt = S_AUTO_SAMPLE;
                        end else if (TURN_TIMEOUT != 0) begin
                            w_to_nxt = r_to + 1'b1;
                        end
                    end
                end

                S_AUTO_SAMPLE, S_CPU_SAMPLE: begin
                    w_err_nxt = bus.move_valid;
                    if (w_sample_ok || (r_try == TRY_LAST)) begin
                        if (r_state == S_AUTO_SAMPLE) begin
                            w_xcells_nxt = r_xcells | w_pick_mask;
                            w_mover_nxt  = 1'b0;
                        end else begin
                            w_ocells_nxt = r_ocells | w_pick_mask;
                            w_mover_nxt  = 1'b1;
                        end
                        w_cmv_nxt   = 1'b1;
                        w_cidx_nxt  = w_pick;
                        w_try_nxt   = '0;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_try_nxt = r_try + 1'b1;
                    end
                end

                S_CHECK: begin
                    w_err_nxt = bus.move_valid;
                    if (w_has_line) begin
                        w_winner_nxt = r_mover ? WIN_O : WIN_X;
                        w_state_nxt  = S_DONE;
                    end else if (w_full) begin
                        w_winner_nxt = WIN_DRAW;
                        w_state_nxt  = S_DONE;
                    end else if (!r_mover) begin
                        w_try_nxt   = '0;
                        w_state_nxt = S_CPU_SAMPLE;
                    end else begin
                        w_to_nxt    = '0;
                        w_state_nxt = S_PLAYER_WAIT;
                    end
                end

                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Boards, counters, result and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xcells <= '0;
            r_ocells <= '0;
            r_mover  <= 1'b0;
            r_try    <= '0;
            r_to     <= '0;
            r_winner <= WIN_NONE;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_cmv    <= 1'b0;
            r_cidx   <= '0;
        end else begin
            r_xcells <= w_xcells_nxt;
            r_ocells <= w_ocells_nxt;
            r_mover  <= w_mover_nxt;
            r_try    <= w_try_nxt;
            r_to     <= w_to_nxt;
            r_winner <= w_winner_nxt;
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_cmv    <= w_cmv_nxt;
            r_cidx   <= w_cidx_nxt;
        end
    end

    assign bus.Xcells         = r_xcells;
    assign bus.Ocells         = r_ocells;
    assign bus.cpu_turn       = (r_state == S_AUTO_SAMPLE) || (r_state == S_CPU_SAMPLE);
    assign bus.move_ack       = r_ack;
    assign bus.move_err       = r_err;
    assign bus.cpu_move_valid = r_cmv;
    assign bus.cpu_move_idx   = r_cidx;
    assign bus.game_over      = (r_state == S_DONE);
    assign bus.winner         = r_winner;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Randomized and directed bench for ttt_turn_controller against a
// cell-array game model.
module tb_ttt_turn_controller;

    localparam int MAX_TRIES    = 8;
    localparam int TURN_TIMEOUT = 16;
    localparam int CPU_FIRST    = 0;

    localparam int P_IDLE = 0, P_PW = 1, P_AUTO = 2, P_CPU = 3, P_CHK = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic reset;

    ttt_turn_controller_if bus ();

    ttt_turn_controller #(
        .MAX_TRIES    (MAX_TRIES),
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .CPU_FIRST    (CPU_FIRST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: cell owner 0 empty, 1 X, 2 O.
    int m_phase;
    int m_cell [9];
    int m_mover;
    int m_try;
    int m_to;
    int m_win;
    int m_ack, m_err, m_cmv, m_cidx;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] m_bits(input int who);
        logic [8:0] b = '0;
        for (int i = 0; i < 9; i++) if (m_cell[i] == who) b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit m_line(input int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who && m_cell[lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return i;
        return 15;
    endfunction

    function automatic bit m_free(input int idx);
        return (idx < 9) && (m_cell[idx] == 0);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_mover = 0; m_try = 0; m_to = 0; m_win = 0;
        m_ack = 0; m_err = 0; m_cmv = 0; m_cidx = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_step(input bit st, input bit mv, input int mi, input int rc);
        int c;
        int mark;
        m_ack = 0; m_err = 0; m_cmv = 0;
        if (st) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            m_win = 0; m_try = 0; m_to = 0;
            m_phase = (CPU_FIRST != 0) ? P_CPU : P_PW;
        end else begin
            case (m_phase)
                P_PW: begin
                    if (mv && m_free(mi)) begin
                        m_cell[mi] = 1; m_ack = 1; m_mover = 1; m_phase = P_CHK;
                    end else begin
                        if (mv) m_err = 1;
                        if (TURN_TIMEOUT != 0 && m_to == TURN_TIMEOUT - 1) begin
                            m_phase = P_AUTO; m_try = 0;
                        end else begin
                            m_to++;
                        end
                    end
                end
                P_AUTO, P_CPU: begin
                    if (mv) m_err = 1;
                    mark = (m_phase == P_AUTO) ? 1 : 2;
                    if (m_free(rc) || m_try == MAX_TRIES - 1) begin
                        c = m_free(rc) ? rc : m_lowest_free();
                        m_cell[c] = mark; m_cmv = 1; m_cidx = c; m_mover = mark; m_phase = P_CHK;
                    end else begin
                        m_try++;
                    end
                end
                P_CHK: begin
                    if (mv) m_err = 1;
                    if (m_line(m_mover)) begin
                        m_win = m_mover; m_phase = P_DONE;
                    end else if (m_full()) begin
                        m_win = 3; m_phase = P_DONE;
                    end else if (m_mover == 1) begin
                        m_phase = P_CPU; m_try = 0;
                    end else begin
                        m_phase = P_PW; m_to = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("Xcells",         32'(bus.Xcells),         32'(m_bits(1)));
        chk("Ocells",         32'(bus.Ocells),         32'(m_bits(2)));
        chk("disjoint",       32'(bus.Xcells & bus.Ocells), 32'd0);
        chk("winner",         32'(bus.winner),         32'(m_win));
        chk("game_over",      32'(bus.game_over),      32'(m_phase == P_DONE));
        chk("cpu_turn",       32'(bus.cpu_turn),       32'(m_phase == P_AUTO || m_phase == P_CPU));
        chk("move_ack",       32'(bus.move_ack),       32'(m_ack));
        chk("move_err",       32'(bus.move_err),       32'(m_err));
        chk("cpu_move_valid", 32'(bus.cpu_move_valid), 32'(m_cmv));
        chk("cpu_move_idx",   32'(bus.cpu_move_idx),   32'(m_cidx));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_X"},    32'(bus.Xcells),         32'd0);
        chk({tag, "_O"},    32'(bus.Ocells),         32'd0);
        chk({tag, "_win"},  32'(bus.winner),         32'd0);
        chk({tag, "_go"},   32'(bus.game_over),      32'd0);
        chk({tag, "_turn"}, 32'(bus.cpu_turn),       32'd0);
        chk({tag, "_ack"},  32'(bus.move_ack),       32'd0);
        chk({tag, "_err"},  32'(bus.move_err),       32'd0);
        chk({tag, "_cmv"},  32'(bus.cpu_move_valid), 32'd0);
        chk({tag, "_cidx"}, 32'(bus.cpu_move_idx),   32'd0);
    endtask

    task automatic step(input bit st, input bit mv, input int mi, input int rc);
        @(negedge clk);
        bus.start      = st;
        bus.move_valid = mv;
        bus.move_idx   = 4'(mi);
        bus.rand_cell  = 4'(rc);
        @(posedge clk);
        model_step(st, mv, mi, rc);
        #1;
        check_all();
    endtask

    task automatic x_move(input int c);
        step(0, 1, c, 15);
        step(0, 0, 0, 15);
    endtask

    task automatic o_move(input int c);
        step(0, 0, 0, c);
        step(0, 0, 0, 15);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(posedge clk);
        #1 check_zero({tag, "_held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        bit st, mv;
        int mi, rc;

        reset = 1'b0;
        bus.start = 1'b0; bus.move_valid = 1'b0; bus.move_idx = '0; bus.rand_cell = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Start, then a player move in the centre.
        step(1, 0, 0, 15);
        chk("t1_go", 32'(bus.game_over), 32'd0);
        step(0, 1, 4, 15);
        chk("t1_x",   32'(bus.Xcells),   32'h010);
        chk("t1_ack", 32'(bus.move_ack), 32'd1);
        step(0, 0, 0, 15);

        // CPU: one occupied suggestion, then cell 0.
        step(0, 0, 0, 4);
        chk("t2_nocommit", 32'(bus.cpu_move_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("t2_cmv", 32'(bus.cpu_move_valid), 32'd1);
        chk("t2_idx", 32'(bus.cpu_move_idx),   32'd0);
        chk("t2_o",   32'(bus.Ocells),         32'h001);

        // Fallback after MAX_TRIES garbage samples.
        step(1, 0, 0, 15);
        x_move(0);
        for (int i = 0; i < MAX_TRIES; i++) step(0, 0, 0, 15);
        chk("t3_cmv", 32'(bus.cpu_move_valid), 32'd1);
        chk("t3_idx", 32'(bus.cpu_move_idx),   32'd1);
        chk("t3_o",   32'(bus.Ocells),         32'h002);

        // X wins across the top row.
        step(1, 0, 0, 15);
        x_move(0); o_move(3); x_move(1); o_move(4); x_move(2);
        chk("t4_win", 32'(bus.winner),    32'd1);
        chk("t4_go",  32'(bus.game_over), 32'd1);
        step(0, 1, 5, 5);
        chk("t4_err",  32'(bus.move_err),       32'd0);
        chk("t4_cmv",  32'(bus.cpu_move_valid), 32'd0);
        chk("t4_frz",  32'(bus.Xcells),         32'h007);

        // Rejections and start/move collision.
        step(1, 0, 0, 15);
        x_move(4); o_move(0);
        step(0, 1, 4, 15);
        chk("t5_occ_err", 32'(bus.move_err), 32'd1);
        chk("t5_occ_x",   32'(bus.Xcells),   32'h010);
        step(0, 1, 9, 15);
        chk("t5_rng_err", 32'(bus.move_err), 32'd1);
        step(1, 1, 4, 15);
        chk("t5_st_x",   32'(bus.Xcells),   32'h000);
        chk("t5_st_ack", 32'(bus.move_ack), 32'd0);

        // Full-board draw.
        step(1, 0, 0, 15);
        x_move(0); o_move(1); x_move(2); o_move(4); x_move(7);
        o_move(5); x_move(3); o_move(6); x_move(8);
        chk("t6_draw", 32'(bus.winner), 32'd3);

        // Player timeout hands X's move to the selector.
        step(1, 0, 0, 15);
        cnt = 0;
        while (!bus.cpu_turn && cnt < 40) begin
            step(0, 0, 0, 15);
            cnt++;
        end
        chk("t6_to_cycles", 32'(cnt), 32'(TURN_TIMEOUT));
        step(0, 0, 0, 3);
        chk("t6_auto_x", 32'(bus.Xcells),         32'h008);
        chk("t6_auto_v", 32'(bus.cpu_move_valid), 32'd1);
        step(0, 0, 0, 15);
        chk("t6_in_cpu", 32'(bus.cpu_turn), 32'd1);
        async_reset("t6_rst");

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 99) < 2) ||
                 ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(0, 99) < 25);
            mv = ($urandom_range(0, 99) < 35);
            mi = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 8) : $urandom_range(9, 15);
            rc = ($urandom_range(0, 99) < 55) ? $urandom_range(0, 8) : $urandom_range(9, 15);
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
            else step(st, mv, mi, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
